// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants and elaboration helpers for updown_counter.
//   DIR_UP / DIR_DOWN   : encodings of the 'up' direction input
//   MODE_WRAP / MODE_SAT: encodings of the 'sat' boundary-mode input
//   max_in_range()      : true when 1 <= max <= 2^width-1
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Legal terminal value for a counter of the given width.
    function automatic bit max_in_range(input int unsigned width,
                                        input longint unsigned max_val);
        longint unsigned limit;
        bit              ok;
        if (width == 32'd0 || width >= 32'd64) begin
            limit = 64'd0;
            ok    = 1'b0;
        end else begin
            limit = (64'd1 << width) - 64'd1;
            ok    = (max_val >= 64'd1) && (max_val <= limit);
        end
        return ok;
    endfunction

endpackage : counter_pkg

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Step-rate prescaler for updown_counter. Compiled only when
// UPDOWN_COUNTER_PRESCALE_EN is defined.
//   clk     in  : clock, rising edge
//   reset   in  : asynchronous active-low reset
//   en      in  : advance the phase counter
//   restart in  : force the phase back to 0 (counter load)
//   tick    out : high while the phase sits at PRESCALE-1
// -----------------------------------------------------------------------------
`ifdef UPDOWN_COUNTER_PRESCALE_EN
module tick_divider #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_r;

    // Phase counter: wraps at PRESCALE-1, frozen while en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= {PW{1'b0}};
        end else if (restart) begin
            phase_r <= {PW{1'b0}};
        end else if (en) begin
            phase_r <= (phase_r == LAST) ? {PW{1'b0}} : phase_r + PW'(1);
        end else begin
            phase_r <= phase_r;
        end
    end

    // With PRESCALE=1 the phase is always LAST, so tick is constantly high.
    assign tick = (phase_r == LAST);

endmodule : tick_divider
`endif

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
// Parametrised up/down counter, range 0..MAX, with wrap or saturate at the
// boundaries, synchronous load, terminal-count pulse and sticky overflow.
// Optional prescaler enabled by macro UPDOWN_COUNTER_PRESCALE_EN.
//   clk      in  : clock, rising edge
//   reset    in  : asynchronous active-low reset
//   en       in  : step enable
//   up       in  : 1 = increment, 0 = decrement
//   sat      in  : 1 = saturate, 0 = wrap
//   load     in  : synchronous load (priority over stepping)
//   load_val in  : load value, clamped to MAX
//   clr_ovf  in  : clear sticky ovf (a simultaneous boundary step wins)
//   count    out : current count (registered)
//   tc       out : one-cycle pulse on every boundary step (registered)
//   ovf      out : sticky boundary flag (registered)
// -----------------------------------------------------------------------------
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned MAX      = 4095,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (!max_in_range(WIDTH, longint'(MAX))) begin : g_bad_max
        $error("updown_counter: MAX must satisfy 1 <= MAX <= 2^WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter: PRESCALE must be >= 1");
    end

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

    logic             tick_s;
    logic             step_s;
    logic             boundary_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ovf_r;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_tick_divider (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (load),
        .tick    (tick_s)
    );
`else
    assign tick_s = 1'b1;
`endif

    assign step_s = en & tick_s & ~load;

    // Next count: load clamps to MAX; boundary handling compares against MAX,
    // not the all-ones value, so non-power-of-two moduli wrap correctly.
    always_comb begin
        count_nxt_s = count_r;
        boundary_s  = 1'b0;
        if (load) begin
            count_nxt_s = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step_s) begin
            if (up == DIR_UP) begin
                if (count_r >= MAX_V) begin
                    boundary_s  = 1'b1;
                    count_nxt_s = (sat == MODE_SAT) ? MAX_V : ZERO_V;
                end else begin
                    count_nxt_s = count_r + WIDTH'(1);
                end
            end else begin
                if (count_r == ZERO_V) begin
                    boundary_s  = 1'b1;
                    count_nxt_s = (sat == MODE_SAT) ? ZERO_V : MAX_V;
                end else begin
                    count_nxt_s = count_r - WIDTH'(1);
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Output registers; ovf set has priority over clr_ovf.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= ZERO_V;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tc_r    <= boundary_s;
            ovf_r   <= boundary_s | (ovf_r & ~clr_ovf);
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign ovf   = ovf_r;

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
module tb_updown_counter;

    localparam int W  = 4;
    localparam int MX = 9;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         sat = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // behavioural reference state
    int m_count = 0;
    int m_tc    = 0;
    int m_ovf   = 0;
    int m_phase = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(W), .MAX(MX), .PRESCALE(PS)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .count(count), .tc(tc), .ovf(ovf)
    );

    typedef struct {
        logic ld; int lv; logic e; logic u; logic s; logic c;
        int exp_count; int exp_tc; int exp_ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_count = 0; m_tc = 0; m_ovf = 0; m_phase = 0;
    endfunction

    // Reference behaviour: modular arithmetic over the range 0..MX.
    function automatic void model_edge();
        int bnd;
        int tick;
        if (load) begin
            m_count = (int'(load_val) > MX) ? MX : int'(load_val);
            m_phase = 0;
            m_tc    = 0;
            m_ovf   = (m_ovf != 0 && !clr_ovf) ? 1 : 0;
        end else begin
            tick = (m_phase == PS - 1) ? 1 : 0;
            if (en) m_phase = (m_phase + 1) % PS;
            bnd = 0;
            if (en && tick != 0) begin
                bnd = up ? (m_count == MX) : (m_count == 0);
                if (!(sat && bnd != 0))
                    m_count = up ? (m_count + 1) % (MX + 1) : (m_count + MX) % (MX + 1);
            end
            m_tc  = bnd;
            m_ovf = (bnd != 0 || (m_ovf != 0 && !clr_ovf)) ? 1 : 0;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; load = 1'b0; clr_ovf = 1'b0; load_val = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vec_t tbl[13];

        // --- reset, then async reset with a nonzero count ---
        do_reset();
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_ovf", int'(ovf), 0);
        load = 1'b1; load_val = 4'd5;
        cyc();
        load = 1'b0;
        chk("preload5", int'(count), 5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_tc", int'(tc), 0);
        chk("async_rst_ovf", int'(ovf), 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("held_rst_count", int'(count), 0);
        reset = 1'b1;

`ifndef UPDOWN_COUNTER_PRESCALE_EN
        // --- table-driven vectors, MAX=9 ---
        tbl[0]  = '{1'b1, 15, 1'b1, 1'b1, 1'b0, 1'b0, 9, 0, 0};
        tbl[1]  = '{1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1};
        tbl[2]  = '{1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1};
        tbl[3]  = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0};
        tbl[4]  = '{1'b0, 0,  1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0};
        tbl[5]  = '{1'b0, 0,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1};
        tbl[6]  = '{1'b0, 0,  1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1};
        tbl[7]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 9, 1, 1};
        tbl[8]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 9, 0, 0};
        tbl[9]  = '{1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b0, 9, 1, 1};
        tbl[10] = '{1'b1, 4,  1'b1, 1'b1, 1'b0, 1'b0, 4, 0, 1};
        tbl[11] = '{1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 1};
        tbl[12] = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1};
        for (int i = 0; i < 13; i++) begin
            load = tbl[i].ld; load_val = W'(tbl[i].lv); en = tbl[i].e;
            up = tbl[i].u; sat = tbl[i].s; clr_ovf = tbl[i].c;
            cyc();
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
            chk($sformatf("tbl%0d_tc", i), int'(tc), tbl[i].exp_tc);
            chk($sformatf("tbl%0d_ovf", i), int'(ovf), tbl[i].exp_ovf);
        end

        // --- wrap up for 10 cycles from 0 ---
        do_reset();
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("wrap%0d_count", i), int'(count), (i + 1) % 10);
            chk($sformatf("wrap%0d_tc", i), int'(tc), (i == 9) ? 1 : 0);
        end
        en = 1'b0;
        cyc();
        chk("wrap_ovf", int'(ovf), 1);

        // --- saturating down from 2 ---
        do_reset();
        load = 1'b1; load_val = 4'd2;
        cyc();
        load = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("satdn%0d_count", i), int'(count), (i == 0) ? 1 : 0);
            chk($sformatf("satdn%0d_tc", i), int'(tc), (i >= 2) ? 1 : 0);
        end
        en = 1'b0; clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("satdn_clr_ovf", int'(ovf), 0);

        // --- count to 5 then async reset mid-count ---
        do_reset();
        en = 1'b1; up = 1'b1; sat = 1'b0;
        repeat (5) cyc();
        chk("mid_count5", int'(count), 5);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        reset = 1'b1;
`else
        // --- prescaled stepping, PRESCALE=4 ---
        do_reset();
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk($sformatf("ps%0d_count", i), int'(count), (i + 1) / 4);
            chk($sformatf("ps%0d_tc", i), int'(tc), 0);
        end
        repeat (2) cyc();
        en = 1'b0;
        repeat (2) cyc();
        chk("ps_frozen", int'(count), 3);
        en = 1'b1;
        cyc();
        chk("ps_resume1", int'(count), 3);
        cyc();
        chk("ps_resume2", int'(count), 4);
`endif

        // --- randomized stimulus against the reference model ---
        do_reset();
        for (int i = 0; i < 400; i++) begin
            load     = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 2) != 0);
            sat      = $urandom_range(0, 1) != 0;
            clr_ovf  = ($urandom_range(0, 7) == 0);
            cyc();
            chk($sformatf("rnd%0d_count", i), int'(count), m_count);
            chk($sformatf("rnd%0d_tc", i), int'(tc), m_tc);
            chk($sformatf("rnd%0d_ovf", i), int'(ovf), m_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_updown_counter
